// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default widths, also used by the ROM and decode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Byte stride between consecutive instruction words.
    localparam int INSTR_BYTES = 4;

    localparam int          FETCH_ADDR_WIDTH = 8;
    localparam int          FETCH_DATA_WIDTH = 32;
    localparam int          FETCH_PC_WIDTH   = 32;
    localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register with flush, reusable between pipeline stages.
// Latency: one edge from load to valid.
// Backpressure: holds its item while valid && !ready; it drains on accept unless reloaded.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   flush                drop the held item (wins over load)
//   load                 capture load_data/load_pc; caller asserts only when (!valid || ready)
//   load_data, load_pc   item to capture
//   ready                consumer accepts when valid && ready
//   valid, data, pc      registered item toward the consumer
module fetch_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [PC_WIDTH-1:0]   load_pc,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [PC_WIDTH-1:0]   pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            // Payload is left stale; only valid matters to the consumer.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses a combinational ROM and registers the word toward decode.
// Latency: rom_addr_o is combinational from the PC; instr_o follows one edge later; redirect costs two cycles.
// Backpressure: the output item and the PC hold while valid_o && !ready_i; halt drains the pending item then idles.
//
// Ports:
//   clk_i, rst_i               clock and asynchronous active-high reset
//   rom_addr_o / rom_data_i    word address to ROM and the word it returns
//   redirect_i, redirect_pc_i  branch/jump target load with output flush
//   halt_i                     stop issuing new fetches
//   instr_o, pc_o, valid_o     registered instruction, its byte address, and valid
//   ready_i                    downstream accept
//   fetch_count_o              number of accepted handshakes (wraps)
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                   ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int                   DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int                   PC_WIDTH   = FETCH_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = FETCH_RESET_PC[PC_WIDTH-1:0]
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    input  logic                  halt_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [31:0]           fetch_count_o
);

    fetch_state_e        state_q;
    fetch_state_e        state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic                load;
    logic                flush;
    logic                accept;

    assign rom_addr_o = pc_q[ADDR_WIDTH+1:2];
    // A handshake completes on this edge whatever else happens, even under redirect.
    assign accept     = valid_o && ready_i;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        flush   = 1'b0;
        if (redirect_i) begin
            // Redirect overrides halt; halt is looked at again next cycle.
            flush   = 1'b1;
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: state_d = halt_i ? HALT : RUN;
                RUN: begin
                    if (halt_i) begin
                        state_d = HALT;
                    end else begin
                        load = !valid_o || ready_i;
                    end
                end
                HALT: begin
                    if (!halt_i) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else if (redirect_i) begin
            pc_q <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
        end else if (load) begin
            pc_q <= pc_q + PC_WIDTH'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_count_o <= '0;
        end else if (accept) begin
            fetch_count_o <= fetch_count_o + 32'd1;
        end
    end

    fetch_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .PC_WIDTH   (PC_WIDTH)
    ) u_out_reg (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (flush),
        .load      (load),
        .load_data (rom_data_i),
        .load_pc   (pc_q),
        .ready     (ready_i),
        .valid     (valid_o),
        .data      (instr_o),
        .pc        (pc_o)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random redirect/halt/ready/reset traffic.
// The reference tracks the next fetch address, the item on offer and the halted/started status.
// A combinational ROM model returns 32'h1000_0000 + word address.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] m_next;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_vld;
    bit          m_started;
    bit          m_halted;

    always #5 clk = ~clk;

    assign rom_data = 32'h1000_0000 + {24'h0, rom_addr};

    instr_fetch dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .halt_i        (halt),
        .instr_o       (instr),
        .pc_o          (pc),
        .valid_o       (valid),
        .ready_i       (ready),
        .fetch_count_o (fetch_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_next    = 32'h0;
        m_pc      = 32'h0;
        m_cnt     = 32'h0;
        m_vld     = 1'b0;
        m_started = 1'b0;
        m_halted  = 1'b0;
    endtask

    // One clock edge of the stage as seen from outside.
    task automatic model_edge(input bit rd, input logic [31:0] tgt, input bit hl, input bit rdy);
        bit took;
        took = m_vld && rdy;
        if (took) m_cnt = m_cnt + 1;
        if (rd) begin
            m_next    = tgt & 32'hFFFF_FFFC;
            m_vld     = 1'b0;
            m_halted  = 1'b0;
            m_started = 1'b1;
        end else if (!m_started) begin
            m_started = 1'b1;
            m_halted  = hl;
        end else if (m_halted || hl) begin
            if (took) m_vld = 1'b0;
            m_halted = hl;
            // Leaving halt takes its own edge; fetching resumes on the next.
            if (!hl) m_halted = 1'b0;
        end else if (!m_vld || rdy) begin
            m_pc   = m_next;
            m_vld  = 1'b1;
            m_next = m_next + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] word_idx;
        word_idx = (m_next >> 2) & 32'hFF;
        check_eq({tag, "_vld"}, {31'h0, valid}, {31'h0, m_vld});
        if (m_vld) begin
            check_eq({tag, "_pc"}, pc, m_pc);
            check_eq({tag, "_instr"}, instr, 32'h1000_0000 + ((m_pc >> 2) & 32'hFF));
        end
        check_eq({tag, "_cnt"}, fetch_count, m_cnt);
        check_eq({tag, "_addr"}, {24'h0, rom_addr}, word_idx);
    endtask

    // Leaving halt is modelled in model_edge: when the edge sees !hl in halt, it only clears the flag.
    task automatic cycle(input bit rd, input logic [31:0] tgt, input bit hl, input bit rdy, input string tag);
        redirect    = rd;
        redirect_pc = tgt;
        halt        = hl;
        ready       = rdy;
        @(posedge clk);
        model_edge(rd, tgt, hl, rdy);
        @(negedge clk);
        check_all(tag);
    endtask

    // Asserts reset between edges, checks the immediate effect, releases on a later falling edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check_eq({tag, "_async_vld"}, {31'h0, valid}, 32'h0);
        check_eq({tag, "_async_cnt"}, fetch_count, 32'h0);
        check_eq({tag, "_async_addr"}, {24'h0, rom_addr}, 32'h0);
        check_eq({tag, "_async_instr"}, instr, 32'h0);
        check_eq({tag, "_async_pc"}, pc, 32'h0);
        model_reset();
        redirect = 1'b0;
        halt     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_all({tag, "_rel"});
    endtask

    initial begin
        bit          r_rd;
        bit          r_hl;
        bit          r_rdy;
        logic [31:0] r_tgt;

        model_reset();
        do_reset("por");

        // 1: start-up stream
        cycle(0, 0, 0, 1, "s1_idle");
        check_eq("s1_idle_const", {31'h0, valid}, 32'h0);
        cycle(0, 0, 0, 1, "s1_b0");
        check_eq("s1_instr0", instr, 32'h1000_0000);
        cycle(0, 0, 0, 1, "s1_b1");
        check_eq("s1_instr1", instr, 32'h1000_0001);
        cycle(0, 0, 0, 1, "s1_b2");
        check_eq("s1_instr2", instr, 32'h1000_0002);
        check_eq("s1_pc2", pc, 32'h8);

        // 2: backpressure
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, "s2_stall");
            check_eq("s2_hold_pc", pc, 32'h8);
            check_eq("s2_hold_addr", {24'h0, rom_addr}, 32'd3);
        end
        cycle(0, 0, 0, 1, "s2_resume");
        check_eq("s2_next_pc", pc, 32'hC);
        check_eq("s2_count3", fetch_count, 32'd3);

        // 3: redirect while stalled, then unaligned target
        cycle(0, 0, 0, 0, "s3_stall");
        cycle(1, 32'h40, 0, 0, "s3_redir");
        check_eq("s3_flush", {31'h0, valid}, 32'h0);
        cycle(0, 0, 0, 1, "s3_tgt");
        check_eq("s3_tgt_pc", pc, 32'h40);
        check_eq("s3_tgt_instr", instr, 32'h1000_0010);
        cycle(1, 32'h43, 0, 1, "s3_redir43");
        cycle(0, 0, 0, 1, "s3_tgt43");
        check_eq("s3_tgt43_pc", pc, 32'h40);

        // 4: halt pulse at pc 8
        cycle(1, 32'h0, 0, 1, "s4_redir0");
        cycle(0, 0, 0, 1, "s4_b0");
        cycle(0, 0, 0, 1, "s4_b1");
        cycle(0, 0, 0, 1, "s4_b2");
        check_eq("s4_at8", pc, 32'h8);
        cycle(0, 0, 1, 1, "s4_halt0");
        cycle(0, 0, 1, 1, "s4_halt1");
        check_eq("s4_halt_vld", {31'h0, valid}, 32'h0);
        check_eq("s4_halt_addr", {24'h0, rom_addr}, 32'd3);
        cycle(0, 0, 0, 1, "s4_rel");
        cycle(0, 0, 0, 1, "s4_resume");
        check_eq("s4_resume_pc", pc, 32'hC);

        // 5: ROM address aliasing
        cycle(1, 32'h3FC, 0, 1, "s5_redir");
        check_eq("s5_addr255", {24'h0, rom_addr}, 32'd255);
        cycle(0, 0, 0, 1, "s5_b0");
        check_eq("s5_pc3fc", pc, 32'h3FC);
        check_eq("s5_addr0", {24'h0, rom_addr}, 32'd0);
        cycle(0, 0, 0, 1, "s5_b1");
        check_eq("s5_pc400", pc, 32'h400);
        check_eq("s5_alias", instr, 32'h1000_0000);

        // 6: asynchronous reset mid-stall, then restart
        cycle(0, 0, 0, 0, "s6_stall");
        do_reset("s6");
        cycle(0, 0, 0, 1, "s6_idle");
        cycle(0, 0, 0, 1, "s6_b0");
        check_eq("s6_restart_instr", instr, 32'h1000_0000);
        check_eq("s6_restart_pc", pc, 32'h0);

        // Random traffic, including 32-bit PC wrap targets and occasional resets
        r_hl = 1'b0;
        for (int i = 0; i < 800; i++) begin
            r_rd  = ($urandom_range(15) == 0);
            r_tgt = $urandom;
            if ($urandom_range(3) == 0) r_tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            if ($urandom_range(11) == 0) r_hl = ~r_hl;
            r_rdy = ($urandom_range(3) != 0);
            if ($urandom_range(249) == 0) begin
                do_reset("rnd_rst");
            end else begin
                cycle(r_rd, r_tgt, r_hl, r_rdy, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
